// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch stage: instruction words, fetch-queue entries,
// the fetch FSM state encoding and a saturating counter helper.
package fetch_pc_unit_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred_taken;
        word_t pred_target;
    } fq_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

    localparam word_t WORD_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic word_t sat_inc(input word_t value);
        return (value == WORD_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_queue.sv
// fetch_queue: small synchronous FIFO of fq_entry_t between fetch and decode.
// Flush has priority over push and pop. The head entry is read straight from
// the register array so a pushed entry is visible the cycle after the push.
module fetch_queue
    import fetch_pc_unit_pkg::*;
#(
    parameter int FQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  fq_entry_t                 push_data,
    output fq_entry_t                 head,
    output logic [$clog2(FQ_DEPTH):0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem_reg [FQ_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == CW'(FQ_DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];

    // Per-slot storage; cleared on reset so the head reads as zero afterwards.
    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (srst) begin
                mem_reg[gi] <= '0;
            end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the fetch PC, issues instruction reads, chooses the next
// PC from the btb prediction or a backend redirect, and queues fetched words
// toward decode. Optional perf counters are built when FETCH_PERF_EN is defined.
// nRST is an active-high synchronous reset despite its name.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic [31:0] pc_fetch,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_instr,
    output logic [31:0] fq_pc,
    output logic        fq_pred_taken,
`ifdef FETCH_PERF_EN
    output logic [31:0] fq_pred_target,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_taken_cnt,
    output logic [31:0] perf_flush_cnt
`else
    output logic [31:0] fq_pred_target
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t  state_reg;
    word_t         pc_reg;
    logic          fire;
    logic          pop;
    logic          fq_full;
    logic          fq_empty;
    logic [CW-1:0] fq_count;
    fq_entry_t     push_entry;
    fq_entry_t     head_entry;

    // A full queue suppresses the request even in FETCH so nothing is dropped.
    assign imem_req  = (state_reg == FETCH) && !fq_full;
    assign fire      = imem_req && imem_ready && !redirect_valid;
    assign pop       = fq_valid && fq_ready;
    assign pc_fetch  = pc_reg;
    assign imem_addr = pc_reg;

    assign push_entry.instr       = imem_rdata;
    assign push_entry.pc          = pc_reg;
    assign push_entry.pred_taken  = btb_hit;
    assign push_entry.pred_target = btb_hit ? btb_target : 32'd0;

    assign fq_valid       = !fq_empty;
    assign fq_instr       = head_entry.instr;
    assign fq_pc          = head_entry.pc;
    assign fq_pred_taken  = head_entry.pred_taken;
    assign fq_pred_target = head_entry.pred_target;

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (CLK),
        .srst      (nRST),
        .push      (fire),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head_entry),
        .count     (fq_count),
        .full      (fq_full),
        .empty     (fq_empty)
    );

    // Next-PC selection: redirect (word aligned) beats the btb, which beats PC+4.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            pc_reg <= btb_hit ? btb_target : pc_reg + 32'd4;
        end
    end

    // Fetch FSM. A pop in the same cycle the queue is seen full keeps fetching,
    // otherwise FULL would wait for a second pop that may never come.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_reg <= BOOT;
        end else if (redirect_valid) begin
            state_reg <= FETCH;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= FETCH;
                FETCH:   state_reg <= ((fq_count == CW'(FQ_DEPTH)) && !pop) ? FULL : FETCH;
                FULL:    state_reg <= pop ? FETCH : FULL;
                default: state_reg <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_taken_reg;
    logic [31:0] perf_flush_reg;

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_stall_cnt = perf_stall_reg;
    assign perf_taken_cnt = perf_taken_reg;
    assign perf_flush_cnt = perf_flush_reg;

    // Saturating event counters for fetches, stalls, predicted-taken pushes and flushes.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            perf_fetch_reg <= '0;
            perf_stall_reg <= '0;
            perf_taken_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (fire) begin
                perf_fetch_reg <= sat_inc(perf_fetch_reg);
            end
            if ((state_reg == FULL) || (imem_req && !imem_ready)) begin
                perf_stall_reg <= sat_inc(perf_stall_reg);
            end
            if (fire && btb_hit) begin
                perf_taken_reg <= sat_inc(perf_taken_reg);
            end
            if (redirect_valid) begin
                perf_flush_reg <= sat_inc(perf_flush_reg);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by random
// traffic, checked against a cycle-level reference model and a scoreboard of
// expected fetch-queue entries consumed by an independent monitor.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pc_fetch;
    logic        btb_hit = 1'b0;
    logic [31:0] btb_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fq_valid;
    logic        fq_ready = 1'b0;
    logic [31:0] fq_instr;
    logic [31:0] fq_pc;
    logic        fq_pred_taken;
    logic [31:0] fq_pred_target;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_taken_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 CLK = ~CLK;

    fetch_pc_unit #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .pc_fetch       (pc_fetch),
        .btb_hit        (btb_hit),
        .btb_target     (btb_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_valid       (fq_valid),
        .fq_ready       (fq_ready),
        .fq_instr       (fq_instr),
        .fq_pc          (fq_pc),
        .fq_pred_taken  (fq_pred_taken),
`ifdef FETCH_PERF_EN
        .fq_pred_target (fq_pred_target),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_taken_cnt (perf_taken_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`else
        .fq_pred_target (fq_pred_target)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: the architectural view of the fetch unit.
    logic [31:0] m_pc = '0;
    int          m_cnt = 0;
    bit          m_boot = 1'b0;      // first cycle after reset issues nothing
    bit          m_stall = 1'b0;     // waiting for decode to drain a full queue
    bit          m_live = 1'b0;
    bit          m_after_rst = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic rst, input logic ir, input logic fr, input logic rv,
                        input logic [31:0] rpc, input logic bh, input logic [31:0] bt);
        bit   req;
        bit   fire;
        bit   pop;
        ent_t e;
        @(negedge CLK);
        nRST           = rst;
        imem_ready     = ir;
        fq_ready       = fr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        btb_hit        = bh;
        btb_target     = bt;
        imem_rdata     = $urandom();
        #1;
        req = !m_boot && !m_stall && (m_cnt < DEPTH);
        if (m_live) begin
            chk("imem_req", 32'(imem_req), 32'(req));
            chk("pc_fetch", pc_fetch, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("fq_valid", 32'(fq_valid), 32'(m_cnt > 0));
            if (m_after_rst) begin
                chk("rst_fq_instr", fq_instr, 32'd0);
                chk("rst_fq_pc", fq_pc, 32'd0);
                chk("rst_fq_taken", 32'(fq_pred_taken), 32'd0);
                chk("rst_fq_target", fq_pred_target, 32'd0);
            end
        end
        m_after_rst = 1'b0;
        if (rst) begin
            m_pc = RESET_PC;
            m_cnt = 0;
            m_boot = 1'b1;
            m_stall = 1'b0;
            m_live = 1'b1;
            m_after_rst = 1'b1;
            exp_q.delete();
        end else if (m_live) begin
            if (rv) begin
                m_pc = {rpc[31:2], 2'b00};
                m_cnt = 0;
                m_boot = 1'b0;
                m_stall = 1'b0;
                exp_q.delete();
            end else begin
                fire = req && ir;
                pop = (m_cnt > 0) && fr;
                if (fire) begin
                    e.instr  = imem_rdata;
                    e.pc     = m_pc;
                    e.taken  = bh;
                    e.target = bh ? bt : 32'd0;
                    exp_q.push_back(e);
                    m_pc = bh ? bt : m_pc + 32'd4;
                end
                if (m_boot) begin
                    m_boot = 1'b0;
                end else if (m_stall || (m_cnt == DEPTH)) begin
                    m_stall = !pop;
                end
                m_cnt = m_cnt + int'(fire) - int'(pop);
            end
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge CLK) begin
        ent_t e;
        #2;
        if (m_live && !nRST && !redirect_valid && fq_valid && fq_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=fq_pc %h expected=no entry t=%0t", fq_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("fq_instr", fq_instr, e.instr);
                chk("fq_pc", fq_pc, e.pc);
                chk("fq_pred_taken", 32'(fq_pred_taken), 32'(e.taken));
                chk("fq_pred_target", fq_pred_target, e.target);
                $display("pop pc=%h instr=%h taken=%0b target=%h", fq_pc, fq_instr, fq_pred_taken, fq_pred_target);
            end
        end
    end

    initial begin
        // Sequential fetch from reset, with a btb hit at PC 8.
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);                   // BOOT: no request
        step(0, 1, 1, 0, 0, 0, 0);                   // pc 0
        step(0, 1, 1, 0, 0, 0, 0);                   // pc 4
        step(0, 1, 1, 0, 0, 1, 32'h100);             // pc 8, predicted taken
        step(0, 1, 1, 0, 0, 0, 0);                   // pc 0x100
        step(0, 1, 1, 0, 0, 0, 0);

        // Fill the queue, stall in FULL, release with a single pop.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);                   // pop entry for pc 0
        step(0, 1, 0, 0, 0, 0, 0);                   // pc 0x10 fetched
        step(0, 1, 0, 0, 0, 0, 0);

        // Redirect with three entries queued and a same-cycle fetch.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h203, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);                   // pc 0x200, queue empty

        // Memory wait of five cycles at 0x40.
        step(0, 1, 1, 1, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);

        // PC wrap at the top of the address space, then reset while FULL.
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);                   // pc 0xFFFFFFFC
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0),
                 $urandom(),
                 ($urandom_range(0, 3) == 0),
                 {$urandom() >> 2, 2'b00});
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Fetch stage directly upstream of the btb.
- Owns the architectural fetch PC and drives pc_fetch to the btb.
- Issues instruction-memory reads and picks the next PC from the btb prediction or a backend redirect.
- Buffers fetched instructions plus prediction metadata in a small FIFO (fetch queue) toward decode.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FQ_DEPTH, 4, fetch-queue entries; power of two, >=2

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  reset; synchronous, active-high (1 = reset), name kept per codebase convention
pc_fetch  out  32  current fetch PC to btb lookup
btb_hit  in  1  btb hit for pc_fetch, combinational same cycle
btb_target  in  32  predicted target for pc_fetch, valid when btb_hit
imem_req  out  1  instruction read request
imem_addr  out  32  read address, equals pc_fetch
imem_ready  in  1  imem_rdata valid this cycle for imem_addr
imem_rdata  in  32  instruction word
redirect_valid  in  1  backend mispredict/exception redirect
redirect_pc  in  32  redirect target
fq_valid  out  1  queue head valid
fq_ready  in  1  decode accepts head
fq_instr  out  32  head instruction
fq_pc  out  32  head PC
fq_pred_taken  out  1  head was predicted taken
fq_pred_target  out  32  head predicted target (0 when not taken)

Behaviour:
- Reset (nRST=1 at a clock edge):
  - PC <= RESET_PC, state <= BOOT, queue emptied.
  - Outputs: imem_req=0, fq_valid=0, pc_fetch=RESET_PC, fq_* data=0.
- FSM states:
  - BOOT: one idle cycle, imem_req=0; next state FETCH.
  - FETCH: imem_req=1. If count==FQ_DEPTH at the cycle start, go to FULL and drop imem_req.
  - FULL: imem_req=0. Return to FETCH the cycle after a pop.
- Fetch fire = imem_req & imem_ready & !redirect_valid:
  - Push {instr, pc, btb_hit, btb_hit?btb_target:0}.
  - Next PC = btb_hit ? btb_target : PC+4. PC+4 wraps modulo 2^32.
  - imem_ready=0 while requesting: hold PC and request, no push. The wait is unbounded.
- Redirect (any state, including BOOT and FULL) has top priority:
  - PC <= {redirect_pc[31:2],2'b00}.
  - Queue flushed (count=0, pointers reset).
  - Same-cycle fetch fire and pop are both discarded.
  - state <= FETCH.
- Pop = fq_valid & fq_ready.
  - Same-cycle push and pop when not full: count unchanged.
  - When full, push is blocked even if a pop occurs. There is no full-queue bypass; the freed slot is used next cycle.
- Queue pointers wrap modulo FQ_DEPTH. Count width is clog2(FQ_DEPTH)+1.
- Empty-queue latency: a pushed entry appears at fq_valid the next cycle (registered). There is no fetch-to-decode combinational path.
- fq_* outputs are driven from the head entry. They are don't-care when fq_valid=0 but must be 0 after reset.
- Reset asserted mid-request or mid-redirect overrides everything.

Optional Feature:
FETCH_PERF_EN
- Defined: adds 32-bit outputs perf_fetch_cnt (fetch fires), perf_stall_cnt (cycles in FULL or imem_req&!imem_ready), perf_taken_cnt (pushes with btb_hit), perf_flush_cnt (redirects).
- Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- datapath_types package gains:
  - fq_entry_t struct {word_t instr; word_t pc; logic pred_taken; word_t pred_target;}
  - fetch_state_t enum {BOOT, FETCH, FULL}
- Sub-module fetch_queue (parameter FQ_DEPTH):
  - Synchronous FIFO of fq_entry_t.
  - Interface: push, pop, flush, head, count, full, empty.
  - fetch_pc_unit holds the PC register, FSM and next-PC mux.

Test Plan:
- Reset then imem_ready=1, btb_hit=0, fq_ready=1:
  - BOOT cycle has imem_req=0.
  - Then pc_fetch = 0,4,8,C on successive cycles.
  - fq_pc follows one cycle later, fq_pred_taken=0.
- Fetch at PC=8 with btb_hit=1, btb_target=0x100:
  - Next pc_fetch=0x100.
  - Entry fq_pc=8, fq_pred_taken=1, fq_pred_target=0x100.
- fq_ready=0, imem_ready=1, FQ_DEPTH=4:
  - Exactly 4 pushes (PCs 0..C), then state FULL with imem_req=0 and pc_fetch=0x10 held.
  - fq_ready=1 for one cycle: pop fq_pc=0, next cycle imem_req=1 and 0x10 is fetched.
- Queue holding 3 entries, redirect_valid=1, redirect_pc=0x203, imem_ready=1 same cycle:
  - Next cycle fq_valid=0 and pc_fetch=0x200.
  - Entry for the old PC is not pushed.
- imem_ready low for 5 cycles at PC=0x40:
  - imem_req=1 and imem_addr=0x40 stable throughout, no push.
  - Push occurs on the cycle imem_ready rises.
- PC=0xFFFF_FFFC, btb_hit=0: next pc_fetch=0. Also assert nRST mid-FULL: next cycle pc_fetch=RESET_PC, fq_valid=0.
